// File: rtl/pcm_sample_buffer.sv
// -----------------------------------------------------------------------------
// pcm_sample_buffer
//
// Ping-pong buffer for signed 24-bit PCM samples. This is also the producer end
// of the RAM consumer interface used by the VU meter and later audio consumers.
// Front-end samples fill one bank of BUFFER_DEPTH words while the other bank is
// streamed out. Each full bank is announced with a one-cycle buffer-ready
// pulse. The bank is then streamed over a valid/ready handshake. The read side
// then idles for GAP_CYCLES before it looks at the next bank.
//
// Optional feature: define SAMPLE_BUF_OVERFLOW_CNT_EN to build a 16-bit
// saturating dropped-sample counter on overflow_count_o. When the macro is
// undefined, that port is tied to zero. The sticky overflow_o flag is present
// in both builds.
//
// Ports:
//   clk_i               system clock
//   rst_i               asynchronous reset, active high
//   sample_i[23:0]      signed PCM sample from the front end
//   sample_valid_i      one-cycle strobe, sample_i valid
//   ram_read_data_o     sample to consumer (mem[rd_bank][rd_idx])
//   ram_read_valid_o    ram_read_data_o valid (STREAM state)
//   ram_read_ready_i    consumer ready
//   ram_buffer_ready_o  one-cycle pulse, a full bank is about to stream
//   overflow_o          sticky, a sample was dropped
//   overflow_count_o    dropped-sample count (0 without the counter feature)
//   debug_o[5:0]        {rd_state[1:0], full[1:0], wr_bank, overflow_o}
// -----------------------------------------------------------------------------

// One storage bank: register array with one write port and an asynchronous
// read port. The contents are reset so that the output data is 0 out of reset.
module pcm_sample_bank #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [23:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [23:0]   rdata
);

  logic [DEPTH-1:0][23:0] mem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

module pcm_sample_buffer #(
  parameter int BUFFER_DEPTH = 16,
  parameter int GAP_CYCLES   = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [23:0] sample_i,
  input  logic        sample_valid_i,
  output logic [23:0] ram_read_data_o,
  output logic        ram_read_valid_o,
  input  logic        ram_read_ready_i,
  output logic        ram_buffer_ready_o,
  output logic        overflow_o,
  output logic [15:0] overflow_count_o,
  output logic [5:0]  debug_o
);

  localparam int IW = $clog2(BUFFER_DEPTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(BUFFER_DEPTH - 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_ANNOUNCE = 2'd1;
  localparam logic [1:0] S_STREAM   = 2'd2;
  localparam logic [1:0] S_GAP      = 2'd3;

  logic [1:0]        full;
  logic [1:0]        full_nxt;
  logic              wr_bank;
  logic              rd_bank;
  logic [IW-1:0]     wr_idx;
  logic [IW-1:0]     rd_idx;
  logic [1:0]        rd_state;
  logic [GW-1:0]     gap_cnt;
  logic              overflow;
  logic [1:0][23:0]  bank_rdata;

  logic wr_accept;
  logic wr_drop;
  logic wr_last;
  logic handshake;
  logic rd_last;

  // ---------------------------------------------------------------------------
  // Write side. There is no backpressure, so a sample is either stored or
  // dropped. full[] is the registered value. A bank released by the read side
  // on this same edge still looks full, so the sample is dropped.
  // ---------------------------------------------------------------------------
  assign wr_accept = sample_valid_i & ~full[wr_bank];
  assign wr_drop   = sample_valid_i &  full[wr_bank];
  assign wr_last   = wr_accept && (wr_idx == LAST_IDX);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_bank  <= 1'b0;
      wr_idx   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_accept) begin
        if (wr_last) begin
          wr_idx  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_idx  <= wr_idx + 1'b1;
        end
      end
      if (wr_drop) overflow <= 1'b1;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    pcm_sample_bank #(
      .DEPTH (BUFFER_DEPTH),
      .AW    (IW)
    ) u_bank (
      .clk   (clk_i),
      .rst   (rst_i),
      .we    (wr_accept && (wr_bank == 1'(b))),
      .waddr (wr_idx),
      .wdata (sample_i),
      .raddr (rd_idx),
      .rdata (bank_rdata[b])
    );
  end

  // ---------------------------------------------------------------------------
  // Bank ownership. A set targets the bank being written, which is empty. A
  // clear targets the bank being read, which is full. So when both happen in
  // one cycle they always hit different banks, and both take effect.
  // ---------------------------------------------------------------------------
  always_comb begin
    full_nxt = full;
    if (wr_last) full_nxt[wr_bank] = 1'b1;
    if (rd_last) full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) full <= '0;
    else       full <= full_nxt;
  end

  // ---------------------------------------------------------------------------
  // Read FSM: IDLE -> ANNOUNCE (pulse) -> STREAM -> GAP -> IDLE.
  // The IDLE cycle after a bank fills is the cycle that decides to announce.
  // This gives a pulse one cycle after the last write and data one cycle later.
  // ---------------------------------------------------------------------------
  assign handshake = (rd_state == S_STREAM) && ram_read_ready_i;
  assign rd_last   = handshake && (rd_idx == LAST_IDX);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_state <= S_IDLE;
      rd_bank  <= 1'b0;
      rd_idx   <= '0;
      gap_cnt  <= '0;
    end else begin
      case (rd_state)
        S_IDLE: begin
          if (full[rd_bank]) begin
            rd_state <= S_ANNOUNCE;
            rd_idx   <= '0;
          end
        end
        S_ANNOUNCE: begin
          rd_state <= S_STREAM;
        end
        S_STREAM: begin
          if (handshake) begin
            // The index wraps to 0 on the last word of the bank.
            rd_idx <= rd_idx + 1'b1;
            if (rd_last) begin
              rd_bank  <= ~rd_bank;
              gap_cnt  <= '0;
              rd_state <= (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES - 1)) rd_state <= S_IDLE;
          else                                gap_cnt  <= gap_cnt + 1'b1;
        end
        default: rd_state <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ram_read_data_o    = bank_rdata[rd_bank];
  assign ram_read_valid_o   = (rd_state == S_STREAM);
  assign ram_buffer_ready_o = (rd_state == S_ANNOUNCE);
  assign overflow_o         = overflow;
  assign debug_o            = {rd_state, full, wr_bank, overflow};

`ifdef SAMPLE_BUF_OVERFLOW_CNT_EN
  logic [15:0] ovf_cnt;

  // Saturates at all-ones so a long overload never wraps back to a low count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                              ovf_cnt <= '0;
    else if (wr_drop && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 1'b1;
  end

  assign overflow_count_o = ovf_cnt;
`else
  assign overflow_count_o = '0;
`endif

endmodule

// File: tb/tb_pcm_sample_buffer.sv
// -----------------------------------------------------------------------------
// tb_pcm_sample_buffer: directed self-checking bench for pcm_sample_buffer
// (BUFFER_DEPTH=16, GAP_CYCLES=3). Inputs are driven 1 ns after the rising
// edge, and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_pcm_sample_buffer;

`ifdef SAMPLE_BUF_OVERFLOW_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] sample = '0;
  logic        sample_valid = 1'b0;
  logic        ready = 1'b0;
  logic [23:0] rdata;
  logic        rvalid;
  logic        bufrdy;
  logic        ovf;
  logic [15:0] ovf_cnt;
  logic [5:0]  dbg;

  int n_cmp = 0;
  int n_err = 0;

  pcm_sample_buffer #(.BUFFER_DEPTH(16), .GAP_CYCLES(3)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .sample_i           (sample),
    .sample_valid_i     (sample_valid),
    .ram_read_data_o    (rdata),
    .ram_read_valid_o   (rvalid),
    .ram_read_ready_i   (ready),
    .ram_buffer_ready_o (bufrdy),
    .overflow_o         (ovf),
    .overflow_count_o   (ovf_cnt),
    .debug_o            (dbg)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; sample_valid = 1'b0; ready = 1'b0;
    repeat (2) tick;
    n_cmp++; if (rdata !== 24'd0) begin n_err++; $display("FAIL reset_data: got %0h want 0", rdata); end
    n_cmp++; if (rvalid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", rvalid); end
    n_cmp++; if (bufrdy !== 1'b0) begin n_err++; $display("FAIL reset_pulse: got %b want 0", bufrdy); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    n_cmp++; if (ovf_cnt !== 16'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", ovf_cnt); end
    n_cmp++; if (dbg !== 6'd0) begin n_err++; $display("FAIL reset_dbg: got %b want 000000", dbg); end
    rst = 1'b0;
    tick;
    n_cmp++; if (dbg !== 6'd0 || rvalid !== 1'b0) begin n_err++; $display("FAIL reset_release: dbg %b valid %b want 0", dbg, rvalid); end
  endtask

  // 16 samples spaced 4 cycles apart. The pulse comes 1 cycle after the last
  // write, then 16 data cycles, then 3 gap cycles.
  task automatic test_fill;
    ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      sample = 24'(i); sample_valid = 1'b1;
      tick;
      sample_valid = 1'b0;
      n_cmp++; if (bufrdy !== 1'b0 || rvalid !== 1'b0) begin n_err++; $display("FAIL fill_early: sample %0d pulse %b valid %b want 0", i, bufrdy, rvalid); end
      if (i < 16) begin
        repeat (3) begin
          tick;
          n_cmp++; if (bufrdy !== 1'b0 || rvalid !== 1'b0) begin n_err++; $display("FAIL fill_idle: sample %0d pulse %b valid %b want 0", i, bufrdy, rvalid); end
        end
      end
    end
    n_cmp++; if (dbg[3:1] !== 3'b011) begin n_err++; $display("FAIL fill_full: full/wr_bank %b want 011", dbg[3:1]); end
    tick;
    n_cmp++; if (bufrdy !== 1'b1 || rvalid !== 1'b0) begin n_err++; $display("FAIL fill_pulse: pulse %b valid %b want 1/0", bufrdy, rvalid); end
    for (int k = 1; k <= 16; k++) begin
      tick;
      n_cmp++; if (rvalid !== 1'b1 || bufrdy !== 1'b0 || rdata !== 24'(k)) begin
        n_err++; $display("FAIL fill_stream: valid %b pulse %b data %0d want 1/0/%0d", rvalid, bufrdy, rdata, k);
      end
    end
    repeat (3) begin
      tick;
      n_cmp++; if (rvalid !== 1'b0 || bufrdy !== 1'b0 || dbg[5:4] !== 2'b11) begin
        n_err++; $display("FAIL fill_gap: valid %b pulse %b state %b want 0/0/11", rvalid, bufrdy, dbg[5:4]);
      end
    end
    tick;
    n_cmp++; if (dbg[5:2] !== 4'b0000) begin n_err++; $display("FAIL fill_idle_after: state/full %b want 0000", dbg[5:2]); end
  endtask

  // Ready pattern 1,0,0,1 during STREAM. The data must hold while stalled.
  task automatic test_backpressure;
    bit          seen;
    int          hs;
    logic [23:0] held;
    bit          stalled;
    ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sample = 24'(101 + i); sample_valid = 1'b1;
      tick;
    end
    sample_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (bufrdy) begin seen = 1'b1; break; end
      tick;
    end
    n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL bp_pulse: pulse seen %b want 1", seen); end
    tick;
    hs = 0; stalled = 1'b0; held = '0;
    for (int c = 0; c < 80 && hs < 16; c++) begin
      ready = (c % 4 == 0 || c % 4 == 3);
      n_cmp++; if (rvalid !== 1'b1 || rdata !== 24'(101 + hs)) begin
        n_err++; $display("FAIL bp_data: cycle %0d valid %b data %0d want 1/%0d", c, rvalid, rdata, 101 + hs);
      end
      if (stalled) begin
        n_cmp++; if (rdata !== held) begin n_err++; $display("FAIL bp_hold: data %0d want %0d", rdata, held); end
      end
      stalled = !ready;
      held    = rdata;
      if (ready) hs++;
      tick;
    end
    n_cmp++; if (hs !== 16) begin n_err++; $display("FAIL bp_count: handshakes %0d want 16", hs); end
    n_cmp++; if (rvalid !== 1'b0) begin n_err++; $display("FAIL bp_end: valid %b want 0", rvalid); end
    ready = 1'b1;
    repeat (4) tick;
  endtask

  // Three banks in sequence with ready held high. Samples come every other
  // cycle, because a bank takes 21 cycles to drain (pulse, 16 words, 3 gap,
  // idle), so a strobe every cycle would overrun the writer.
  task automatic test_ping_pong;
    int nin, nout, npulse;
    bit pend;
    int firsts [3];
    nin = 0; nout = 0; npulse = 0; pend = 1'b0;
    firsts[0] = 0; firsts[1] = 0; firsts[2] = 0;
    ready = 1'b1;
    for (int c = 0; c < 400 && nout < 48; c++) begin
      if (c % 2 == 0 && nin < 48) begin
        sample = 24'(nin + 1); sample_valid = 1'b1; nin++;
      end else begin
        sample_valid = 1'b0;
      end
      if (bufrdy) begin
        n_cmp++; if (rvalid !== 1'b0) begin n_err++; $display("FAIL pp_coincide: valid %b with pulse, want 0", rvalid); end
        npulse++; pend = 1'b1;
      end
      if (rvalid) begin
        n_cmp++; if (rdata !== 24'(nout + 1)) begin n_err++; $display("FAIL pp_data: data %0d want %0d", rdata, nout + 1); end
        if (pend && npulse >= 1 && npulse <= 3) firsts[npulse-1] = int'(rdata);
        pend = 1'b0;
        nout++;
      end
      tick;
    end
    sample_valid = 1'b0;
    n_cmp++; if (nout !== 48) begin n_err++; $display("FAIL pp_count: outputs %0d want 48", nout); end
    n_cmp++; if (npulse !== 3) begin n_err++; $display("FAIL pp_pulses: pulses %0d want 3", npulse); end
    n_cmp++; if (firsts[0] !== 1 || firsts[1] !== 17 || firsts[2] !== 33) begin
      n_err++; $display("FAIL pp_order: bank heads %0d %0d %0d want 1 17 33", firsts[0], firsts[1], firsts[2]);
    end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL pp_ovf: overflow %b want 0", ovf); end
    repeat (4) tick;
  endtask

  // Fresh reset, ready low, 40 strobes: banks 0 and 1 fill, samples 33..40 drop.
  task automatic test_overflow;
    rst = 1'b1; tick; rst = 1'b0; ready = 1'b0; tick;
    for (int i = 0; i < 40; i++) begin
      sample = 24'(201 + i); sample_valid = 1'b1;
      tick;
      if (i == 31) begin
        n_cmp++; if (ovf !== 1'b0 || dbg[3:2] !== 2'b11) begin
          n_err++; $display("FAIL ovf_pre: overflow %b full %b want 0/11", ovf, dbg[3:2]);
        end
      end
    end
    sample_valid = 1'b0;
    n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_flag: overflow %b want 1", ovf); end
    n_cmp++; if (ovf_cnt !== (CNT_EN ? 16'd8 : 16'd0)) begin n_err++; $display("FAIL ovf_count: got %0d want %0d", ovf_cnt, CNT_EN ? 8 : 0); end
    n_cmp++; if (dbg[3:1] !== 3'b110) begin n_err++; $display("FAIL ovf_full: full/wr_bank %b want 110", dbg[3:1]); end
    n_cmp++; if (rvalid !== 1'b1 || rdata !== 24'd201) begin n_err++; $display("FAIL ovf_stall: valid %b data %0d want 1/201", rvalid, rdata); end
  endtask

  // Continues from the overflow state. A strobe lands on the cycle of bank 0's
  // last handshake and is dropped. The next strobe opens bank 0 at index 0.
  task automatic test_release_race;
    int h, nxt;
    bit raced;
    int expv [48];
    for (int i = 0; i < 32; i++) expv[i] = 201 + i;
    for (int i = 0; i < 16; i++) expv[32 + i] = 301 + i;
    h = 0; nxt = 301; raced = 1'b0;
    ready = 1'b1;
    for (int c = 0; c < 300 && h < 48; c++) begin
      if (rvalid && h == 15 && !raced) begin
        sample = 24'd300; sample_valid = 1'b1; raced = 1'b1;
      end else if (raced && nxt <= 316) begin
        sample = 24'(nxt); sample_valid = 1'b1; nxt++;
      end else begin
        sample_valid = 1'b0;
      end
      if (rvalid) begin
        n_cmp++; if (rdata !== 24'(expv[h])) begin n_err++; $display("FAIL race_data: item %0d data %0d want %0d", h, rdata, expv[h]); end
        h++;
      end
      tick;
    end
    sample_valid = 1'b0;
    n_cmp++; if (h !== 48) begin n_err++; $display("FAIL race_count: outputs %0d want 48", h); end
    n_cmp++; if (ovf_cnt !== (CNT_EN ? 16'd9 : 16'd0)) begin n_err++; $display("FAIL race_drop: count %0d want %0d", ovf_cnt, CNT_EN ? 9 : 0); end
    repeat (4) tick;
  endtask

  task automatic test_reset_mid_stream;
    bit seen;
    bit quiet;
    ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      sample = 24'(401 + i); sample_valid = 1'b1;
      tick;
    end
    sample_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (bufrdy) begin seen = 1'b1; break; end
      tick;
    end
    n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL rst_pulse: pulse seen %b want 1", seen); end
    tick;
    repeat (7) tick;
    n_cmp++; if (rvalid !== 1'b1 || rdata !== 24'd408) begin n_err++; $display("FAIL rst_idx7: valid %b data %0d want 1/408", rvalid, rdata); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (rdata !== 24'd0 || rvalid !== 1'b0 || bufrdy !== 1'b0) begin
      n_err++; $display("FAIL rst_async: data %0d valid %b pulse %b want 0", rdata, rvalid, bufrdy);
    end
    n_cmp++; if (ovf !== 1'b0 || ovf_cnt !== 16'd0 || dbg !== 6'd0) begin
      n_err++; $display("FAIL rst_async_status: ovf %b cnt %0d dbg %b want 0", ovf, ovf_cnt, dbg);
    end
    tick; tick;
    rst = 1'b0;
    quiet = 1'b1;
    repeat (30) begin
      tick;
      if (bufrdy !== 1'b0 || rvalid !== 1'b0) quiet = 1'b0;
    end
    n_cmp++; if (quiet !== 1'b1) begin n_err++; $display("FAIL rst_quiet: activity after reset %b want none", !quiet); end
    for (int i = 0; i < 16; i++) begin
      sample = 24'(501 + i); sample_valid = 1'b1;
      tick;
    end
    sample_valid = 1'b0;
    n_cmp++; if (bufrdy !== 1'b0) begin n_err++; $display("FAIL rst_refill_early: pulse %b want 0", bufrdy); end
    tick;
    n_cmp++; if (bufrdy !== 1'b1) begin n_err++; $display("FAIL rst_refill_pulse: pulse %b want 1", bufrdy); end
    tick;
    n_cmp++; if (rvalid !== 1'b1 || rdata !== 24'd501) begin n_err++; $display("FAIL rst_refill_data: valid %b data %0d want 1/501", rvalid, rdata); end
  endtask

  initial begin
    test_reset;
    test_fill;
    test_backpressure;
    test_ping_pong;
    test_overflow;
    test_release_race;
    test_reset_mid_stream;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
